hdlverifier_trigger_sequencer: RTL and testbench
================================================

// Module: hdlverifier_trigger_sequencer
// PURPOSE
//  Multi-stage trigger evaluator placed directly upstream of the capture core in the FPGA data-capture IP.
//  Compares probe data against up to NUM_STAGES programmed conditions in sequence.
//  Drives the core's trigger, buffer_enable, current_stage, stage_reset and seq_reset inputs.
//  Armed by the core's start bit; configured from host-written registers.
// PARAMETERS
//  TRIG_WIDTH  22  probe data width compared by each stage
//  NUM_STAGES  4   number of sequential stages; range 1..4
//  COUNT_WIDTH 8   occurrence-count and timeout counter width
// PORTS
//  clk            in   1           capture clock
//  reset_n        in   1           asynchronous reset, active low
//  clk_enable     in   1           sample qualifier; evaluation only on cycles where it is 1
//  start          in   1           arm level from capture core; rising edge arms, low disarms
//  trig_data      in   TRIG_WIDTH  probe signals
//  cfg_wr         in   1           write strobe for stage config
//  cfg_stage      in   2           stage index written
//  cfg_value      in   TRIG_WIDTH  compare value
//  cfg_mask       in   TRIG_WIDTH  compare mask; 1 = bit participates
//  cfg_mode       in   2           00 eq, 01 neq, 10 edge, 11 always
//  cfg_count      in   COUNT_WIDTH occurrences needed; 0 treated as 1
//  cfg_timeout    in   COUNT_WIDTH per-stage timeout in enabled cycles; 0 = none
//  cfg_num_stages in   2           active stages minus 1
//  trigger        out  1           one-cycle pulse on final-stage completion
//  buffer_enable  out  1           clk_enable & (state != IDLE)
//  current_stage  out  4           active stage index
//  stage_reset    out  4           sticky per-stage timeout flags
//  seq_reset      out  1           sticky: sequence restarted at least once
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, config tables 0, counters 0.
//  FSM: IDLE -(start rise)-> ARMED(stage 0) -(last stage done)-> TRIGGERED.
//   Any state -(start=0)-> IDLE next cycle.
//   TRIGGERED holds until start=0; a new rise re-arms.
//  Arming clears occurrence counter, timeout counter, stage_reset and seq_reset.
//  Match, per enabled cycle:
//   eq:   ((d ^ v) & m) == 0
//   neq:  ((d ^ v) & m) != 0
//   edge: ((d ^ d_prev) & m) != 0; d_prev updates on enabled cycles only and is primed on arm.
//  Occurrence counter increments on each enabled match.
//   Stage completes in the cycle the count reaches max(cfg_count, 1).
//   Stage index advances and counter clears on the next clk edge.
//   The new stage evaluates from the following enabled cycle.
//  Final stage (index == cfg_num_stages) completes:
//   trigger=1 for exactly one clk, registered one cycle after the matching sample.
//   Then state TRIGGERED; current_stage holds the last index.
//  Counters saturate at all-ones and never wrap.
//  cfg_wr while ARMED: the table updates, but the current stage keeps its latched count target.
//  cfg_stage >= NUM_STAGES: write is ignored.
//  current_stage = 0 in IDLE.
// CONFIGURATION
//  HDLV_TRIG_TIMEOUT_EN defined: per-stage timeout is enabled.
//   In stage k > 0, the timeout counter counts enabled cycles without completion.
//   When it reaches cfg_timeout (if nonzero): return to stage 0, clear counters, set stage_reset[k] and seq_reset.
//   If completion and timeout occur in the same cycle, completion wins.
//  HDLV_TRIG_TIMEOUT_EN undefined: no timeout logic; cfg_timeout is ignored; stage_reset=0, seq_reset=0.
// STRUCTURE
//  Package hdlverifier_trigger_pkg contains:
//   mode encodings (MODE_EQ/NEQ/EDGE/ALWAYS)
//   FSM state typedef (IDLE/ARMED/TRIGGERED)
//   stage-config struct {value, mask, mode, count, timeout}
//  Sub-module hdlverifier_trigger_stage_cmp: masked compare plus edge detect, returning a match bit.
//   Instantiated once, muxed by the active stage.
// TESTING
//  1 stage, eq, v=22'h0000AB, m=22'h0000FF, count=1; arm; drive 0xAB -> trigger one cycle later; state TRIGGERED; current_stage=0.
//  2 stages: s0 eq 0x01 count=3, s1 edge m=bit0; 3 matches then toggle bit0 -> current_stage 0->1; single trigger pulse.
//  clk_enable low during matching data -> no count and no trigger; buffer_enable=0 while clk_enable=0.
//  start dropped while ARMED at stage 1 -> IDLE next cycle; re-arm -> current_stage=0, counters cleared.
//  HDLV_TRIG_TIMEOUT_EN, s1 timeout=5 with no match -> stage 0 after 5 enabled cycles; stage_reset=4'b0010; seq_reset=1.
//  Match and timeout in the same cycle at final stage -> trigger asserted; stage_reset unchanged.

Source files
------------

// File: rtl/hdlverifier_trigger_pkg.sv
// Shared types and helpers for the multi-stage trigger sequencer.
// Stage configuration fields are sized by TRIG_W / CNT_W; the sequencer's
// TRIG_WIDTH / COUNT_WIDTH parameters must stay equal to these.
package hdlverifier_trigger_pkg;

  localparam int TRIG_W = 22;
  localparam int CNT_W  = 8;

  localparam logic [1:0] MODE_EQ     = 2'b00;
  localparam logic [1:0] MODE_NEQ    = 2'b01;
  localparam logic [1:0] MODE_EDGE   = 2'b10;
  localparam logic [1:0] MODE_ALWAYS = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2
  } state_t;

  typedef struct packed {
    logic [TRIG_W-1:0] value;
    logic [TRIG_W-1:0] mask;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  timeout;
  } stage_cfg_t;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  // A programmed occurrence count of zero behaves as one.
  function automatic logic [CNT_W-1:0] count_target(input logic [CNT_W-1:0] c);
    return (c == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : c;
  endfunction

endpackage

// File: rtl/hdlverifier_trigger_stage_cmp.sv
// Masked compare / edge detect for the currently active trigger stage.
module hdlverifier_trigger_stage_cmp
  import hdlverifier_trigger_pkg::*;
#(
  parameter int W = TRIG_W
) (
  input  logic [W-1:0] d,
  input  logic [W-1:0] d_prev,
  input  logic [W-1:0] value,
  input  logic [W-1:0] mask,
  input  logic [1:0]   mode,
  output logic         match
);

  // Evaluate the selected compare mode on the current sample.
  always_comb begin
    match = 1'b0;
    case (mode)
      MODE_EQ:     match = (((d ^ value) & mask) == '0);
      MODE_NEQ:    match = (((d ^ value) & mask) != '0);
      MODE_EDGE:   match = (((d ^ d_prev) & mask) != '0);
      default:     match = 1'b1;
    endcase
  end

endmodule

// File: rtl/hdlverifier_trigger_sequencer.sv
// Multi-stage trigger sequencer feeding the capture core.
// Optional feature macro: HDLV_TRIG_TIMEOUT_EN (per-stage timeout / restart).
// Handshake: none; start is a level (rising edge arms, low disarms) and
// trigger is a single-cycle pulse one clock after the completing sample.
module hdlverifier_trigger_sequencer
  import hdlverifier_trigger_pkg::*;
#(
  parameter int TRIG_WIDTH  = TRIG_W,
  parameter int NUM_STAGES  = 4,
  parameter int COUNT_WIDTH = CNT_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_enable,
  input  logic                   start,
  input  logic [TRIG_WIDTH-1:0]  trig_data,
  input  logic                   cfg_wr,
  input  logic [1:0]             cfg_stage,
  input  logic [TRIG_WIDTH-1:0]  cfg_value,
  input  logic [TRIG_WIDTH-1:0]  cfg_mask,
  input  logic [1:0]             cfg_mode,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic [COUNT_WIDTH-1:0] cfg_timeout,
  input  logic [1:0]             cfg_num_stages,
  output logic                   trigger,
  output logic                   buffer_enable,
  output logic [3:0]             current_stage,
  output logic [3:0]             stage_reset,
  output logic                   seq_reset,
  output logic [1:0]             dbg_state
);

  stage_cfg_t             cfg_q [NUM_STAGES];
  stage_cfg_t             cfg_d [NUM_STAGES];
  state_t                 state_q, state_d;
  logic [1:0]             stage_q, stage_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] target_q, target_d;
  logic [TRIG_WIDTH-1:0]  d_prev_q, d_prev_d;
  logic                   trigger_q, trigger_d;
  logic                   start_prev_q, start_prev_d;

  logic                   match;
  logic                   start_rise;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic                   stage_done;
  logic [1:0]             last_stage;

`ifdef HDLV_TRIG_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0] to_q, to_d;
  logic [3:0]             stage_reset_q, stage_reset_d;
  logic                   seq_reset_q, seq_reset_d;
  logic [COUNT_WIDTH-1:0] to_inc;
  logic                   timeout_hit;
`endif

  hdlverifier_trigger_stage_cmp #(.W(TRIG_WIDTH)) u_cmp (
    .d      (trig_data),
    .d_prev (d_prev_q),
    .value  (cfg_q[stage_q].value),
    .mask   (cfg_q[stage_q].mask),
    .mode   (cfg_q[stage_q].mode),
    .match  (match)
  );

  // Per-cycle qualifiers: arm edge, occurrence count, completion and last stage.
  always_comb begin
    start_rise = start & ~start_prev_q;
    cnt_inc    = sat_inc(cnt_q);
    stage_done = clk_enable & match & (cnt_inc == target_q);
    last_stage = (int'(cfg_num_stages) >= NUM_STAGES) ? 2'(NUM_STAGES - 1) : cfg_num_stages;
`ifdef HDLV_TRIG_TIMEOUT_EN
    to_inc      = sat_inc(to_q);
    timeout_hit = (stage_q != 2'd0) && (cfg_q[stage_q].timeout != '0) &&
                  (to_inc == cfg_q[stage_q].timeout);
`endif
  end

  // Next-state logic for the config table and the sequencing FSM.
  always_comb begin
    cfg_d        = cfg_q;
    state_d      = state_q;
    stage_d      = stage_q;
    cnt_d        = cnt_q;
    target_d     = target_q;
    d_prev_d     = d_prev_q;
    trigger_d    = 1'b0;
    start_prev_d = start;
`ifdef HDLV_TRIG_TIMEOUT_EN
    to_d          = to_q;
    stage_reset_d = stage_reset_q;
    seq_reset_d   = seq_reset_q;
`endif

    if (cfg_wr && (int'(cfg_stage) < NUM_STAGES)) begin
      cfg_d[cfg_stage] = '{value: cfg_value, mask: cfg_mask, mode: cfg_mode,
                           count: cfg_count, timeout: cfg_timeout};
    end

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d  = ARMED;
          stage_d  = 2'd0;
          cnt_d    = '0;
          target_d = count_target(cfg_q[0].count);
          d_prev_d = trig_data;
`ifdef HDLV_TRIG_TIMEOUT_EN
          to_d          = '0;
          stage_reset_d = 4'd0;
          seq_reset_d   = 1'b0;
`endif
        end
      end
      ARMED: begin
        if (clk_enable) begin
          d_prev_d = trig_data;
          if (match) cnt_d = cnt_inc;
          if (stage_done) begin
            cnt_d = '0;
`ifdef HDLV_TRIG_TIMEOUT_EN
            to_d  = '0;
`endif
            if (stage_q == last_stage) begin
              trigger_d = 1'b1;
              state_d   = TRIGGERED;
            end else begin
              stage_d  = stage_q + 2'd1;
              target_d = count_target(cfg_q[stage_q + 2'd1].count);
            end
          end
`ifdef HDLV_TRIG_TIMEOUT_EN
          else if (stage_q != 2'd0) begin
            to_d = to_inc;
            if (timeout_hit) begin
              stage_d                = 2'd0;
              cnt_d                  = '0;
              to_d                   = '0;
              target_d               = count_target(cfg_q[0].count);
              stage_reset_d[stage_q] = 1'b1;
              seq_reset_d            = 1'b1;
            end
          end
`endif
        end
      end
      default: ;
    endcase

    // Dropping start disarms from any state and takes priority over completion.
    if (!start) begin
      state_d   = IDLE;
      stage_d   = 2'd0;
      cnt_d     = '0;
      trigger_d = 1'b0;
`ifdef HDLV_TRIG_TIMEOUT_EN
      to_d      = '0;
`endif
    end
  end

  // State and table registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STAGES; i++) cfg_q[i] <= '0;
      state_q      <= IDLE;
      stage_q      <= 2'd0;
      cnt_q        <= '0;
      target_q     <= '0;
      d_prev_q     <= '0;
      trigger_q    <= 1'b0;
      start_prev_q <= 1'b0;
`ifdef HDLV_TRIG_TIMEOUT_EN
      to_q          <= '0;
      stage_reset_q <= 4'd0;
      seq_reset_q   <= 1'b0;
`endif
    end else begin
      cfg_q        <= cfg_d;
      state_q      <= state_d;
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      d_prev_q     <= d_prev_d;
      trigger_q    <= trigger_d;
      start_prev_q <= start_prev_d;
`ifdef HDLV_TRIG_TIMEOUT_EN
      to_q          <= to_d;
      stage_reset_q <= stage_reset_d;
      seq_reset_q   <= seq_reset_d;
`endif
    end
  end

`ifdef HDLV_TRIG_TIMEOUT_EN
  assign stage_reset = stage_reset_q;
  assign seq_reset   = seq_reset_q;
`else
  logic unused_timeout;
  // Timeout fields are stored but have no effect without the timeout feature.
  always_comb begin
    unused_timeout = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) unused_timeout = unused_timeout ^ (^cfg_q[i].timeout);
  end
  assign stage_reset = 4'd0;
  assign seq_reset   = 1'b0;
`endif

  assign trigger       = trigger_q;
  assign buffer_enable = clk_enable & (state_q != IDLE);
  assign current_stage = {2'b00, stage_q};
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_hdlverifier_trigger_sequencer.sv
// Self-checking bench for hdlverifier_trigger_sequencer.
module tb_hdlverifier_trigger_sequencer;
  import hdlverifier_trigger_pkg::*;

  localparam int TW = 22;
  localparam int CW = 8;
  localparam logic [TW-1:0] ALL1 = {TW{1'b1}};

`ifdef HDLV_TRIG_TIMEOUT_EN
  localparam logic [3:0] EXP_SR  = 4'b0010;
  localparam logic       EXP_SEQ = 1'b1;
`else
  localparam logic [3:0] EXP_SR  = 4'b0000;
  localparam logic       EXP_SEQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clk_enable;
  logic          start;
  logic [TW-1:0] trig_data;
  logic          cfg_wr;
  logic [1:0]    cfg_stage;
  logic [TW-1:0] cfg_value;
  logic [TW-1:0] cfg_mask;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_count;
  logic [CW-1:0] cfg_timeout;
  logic [1:0]    cfg_num_stages;
  logic          trigger;
  logic          buffer_enable;
  logic [3:0]    current_stage;
  logic [3:0]    stage_reset;
  logic          seq_reset;
  logic [1:0]    dbg_state;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_stage;

  hdlverifier_trigger_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk_enable     (clk_enable),
    .start          (start),
    .trig_data      (trig_data),
    .cfg_wr         (cfg_wr),
    .cfg_stage      (cfg_stage),
    .cfg_value      (cfg_value),
    .cfg_mask       (cfg_mask),
    .cfg_mode       (cfg_mode),
    .cfg_count      (cfg_count),
    .cfg_timeout    (cfg_timeout),
    .cfg_num_stages (cfg_num_stages),
    .trigger        (trigger),
    .buffer_enable  (buffer_enable),
    .current_stage  (current_stage),
    .stage_reset    (stage_reset),
    .seq_reset      (seq_reset),
    .dbg_state      (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: every trigger pulse must match an expected entry (final stage index).
  always @(negedge clk) begin
    if (reset_n === 1'b1 && trigger === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_trigger: trigger=1 at stage %0d, none expected", current_stage);
      end else begin
        exp_stage = exp_q.pop_front();
        if (current_stage !== exp_stage) begin
          n_err++;
          $display("FAIL sb_trigger_stage: current_stage=%0d expected=%0d", current_stage, exp_stage);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] s, input logic [TW-1:0] v, input logic [TW-1:0] m,
                           input logic [1:0] md, input logic [CW-1:0] c, input logic [CW-1:0] t);
    cfg_wr = 1'b1; cfg_stage = s; cfg_value = v; cfg_mask = m;
    cfg_mode = md; cfg_count = c; cfg_timeout = t;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clk_enable = 1'b1; start = 1'b0; trig_data = '0; cfg_wr = 1'b0;
    cfg_stage = '0; cfg_value = '0; cfg_mask = '0; cfg_mode = '0; cfg_count = '0;
    cfg_timeout = '0; cfg_num_stages = '0;
    tick(); tick();
    n_vec++;
    if ({trigger, buffer_enable, current_stage, stage_reset, seq_reset} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: trig=%b be=%b cs=%0d sr=%b seq=%b expected all 0",
               trigger, buffer_enable, current_stage, stage_reset, seq_reset);
    end
    n_vec++;
    if (dbg_state !== IDLE) begin
      n_err++; $display("FAIL reset_state: state=%0d expected=%0d", dbg_state, IDLE);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_eq();
    cfg_num_stages = 2'd0;
    cfg_write(2'd0, 22'h0000AB, 22'h0000FF, MODE_EQ, 8'd1, 8'd0);
    trig_data = '0; start = 1'b1; tick();
    n_vec++;
    if (dbg_state !== ARMED || current_stage !== 4'd0) begin
      n_err++; $display("FAIL eq_armed: state=%0d cs=%0d expected state=1 cs=0", dbg_state, current_stage);
    end
    trig_data = 22'h3F00AB; exp_q.push_back(4'd0); tick();
    n_vec++;
    if (trigger !== 1'b1 || dbg_state !== TRIGGERED || current_stage !== 4'd0) begin
      n_err++;
      $display("FAIL eq_trigger: trig=%b state=%0d cs=%0d expected trig=1 state=2 cs=0",
               trigger, dbg_state, current_stage);
    end
    trig_data = '0; tick();
    n_vec++;
    if (trigger !== 1'b0 || dbg_state !== TRIGGERED) begin
      n_err++; $display("FAIL eq_pulse_end: trig=%b state=%0d expected trig=0 state=2", trigger, dbg_state);
    end
    start = 1'b0; tick();
    n_vec++;
    if (dbg_state !== IDLE) begin
      n_err++; $display("FAIL eq_disarm: state=%0d expected=0", dbg_state);
    end
  endtask

  task automatic test_two_stage_edge();
    cfg_num_stages = 2'd1;
    cfg_write(2'd0, 22'h000001, ALL1, MODE_EQ, 8'd3, 8'd0);
    cfg_write(2'd1, 22'h000000, 22'h000001, MODE_EDGE, 8'd1, 8'd0);
    trig_data = '0; start = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      trig_data = 22'h000001; tick();
      n_vec++;
      if (current_stage !== ((i == 2) ? 4'd1 : 4'd0) || trigger !== 1'b0) begin
        n_err++; $display("FAIL edge_s0_count%0d: cs=%0d trig=%b", i, current_stage, trigger);
      end
    end
    tick();
    n_vec++;
    if (current_stage !== 4'd1 || trigger !== 1'b0) begin
      n_err++; $display("FAIL edge_no_toggle: cs=%0d trig=%b expected cs=1 trig=0", current_stage, trigger);
    end
    trig_data = '0; exp_q.push_back(4'd1); tick();
    n_vec++;
    if (trigger !== 1'b1 || dbg_state !== TRIGGERED || current_stage !== 4'd1) begin
      n_err++; $display("FAIL edge_trigger: trig=%b state=%0d cs=%0d", trigger, dbg_state, current_stage);
    end
    trig_data = 22'h000001; tick();
    n_vec++;
    if (trigger !== 1'b0) begin
      n_err++; $display("FAIL edge_single_pulse: trig=%b expected=0", trigger);
    end
    start = 1'b0; tick();
  endtask

  task automatic test_clk_enable();
    cfg_num_stages = 2'd0;
    cfg_write(2'd0, 22'h0000AB, 22'h0000FF, MODE_EQ, 8'd2, 8'd0);
    trig_data = '0; start = 1'b1; tick();
    clk_enable = 1'b0; trig_data = 22'h0000AB; #1;
    n_vec++;
    if (buffer_enable !== 1'b0) begin
      n_err++; $display("FAIL ce_buffer_enable_low: be=%b expected=0", buffer_enable);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (trigger !== 1'b0 || dbg_state !== ARMED || buffer_enable !== 1'b0) begin
        n_err++; $display("FAIL ce_hold%0d: trig=%b state=%0d be=%b", i, trigger, dbg_state, buffer_enable);
      end
    end
    clk_enable = 1'b1; #1;
    n_vec++;
    if (buffer_enable !== 1'b1) begin
      n_err++; $display("FAIL ce_buffer_enable_high: be=%b expected=1", buffer_enable);
    end
    tick();
    n_vec++;
    if (trigger !== 1'b0) begin
      n_err++; $display("FAIL ce_first_count: trig=%b expected=0", trigger);
    end
    exp_q.push_back(4'd0); tick();
    n_vec++;
    if (trigger !== 1'b1) begin
      n_err++; $display("FAIL ce_trigger: trig=%b expected=1", trigger);
    end
    start = 1'b0; tick();
  endtask

  task automatic test_start_drop();
    cfg_num_stages = 2'd1;
    cfg_write(2'd0, 22'h000001, ALL1, MODE_EQ, 8'd2, 8'd0);
    cfg_write(2'd1, 22'h000002, ALL1, MODE_EQ, 8'd2, 8'd0);
    trig_data = '0; start = 1'b1; tick();
    trig_data = 22'h000001; tick(); tick();
    trig_data = 22'h000002; tick();
    n_vec++;
    if (current_stage !== 4'd1 || trigger !== 1'b0) begin
      n_err++; $display("FAIL drop_at_s1: cs=%0d trig=%b expected cs=1 trig=0", current_stage, trigger);
    end
    start = 1'b0; trig_data = '0; tick();
    n_vec++;
    if (dbg_state !== IDLE || current_stage !== 4'd0 || buffer_enable !== 1'b0) begin
      n_err++; $display("FAIL drop_idle: state=%0d cs=%0d be=%b", dbg_state, current_stage, buffer_enable);
    end
    start = 1'b1; tick();
    trig_data = 22'h000001; tick();
    n_vec++;
    if (current_stage !== 4'd0 || dbg_state !== ARMED) begin
      n_err++; $display("FAIL rearm_cnt_cleared: cs=%0d state=%0d expected cs=0 state=1", current_stage, dbg_state);
    end
    tick();
    trig_data = 22'h000002; tick();
    n_vec++;
    if (current_stage !== 4'd1 || trigger !== 1'b0) begin
      n_err++; $display("FAIL rearm_s1_first: cs=%0d trig=%b expected cs=1 trig=0", current_stage, trigger);
    end
    exp_q.push_back(4'd1); tick();
    n_vec++;
    if (trigger !== 1'b1) begin
      n_err++; $display("FAIL rearm_trigger: trig=%b expected=1", trigger);
    end
    start = 1'b0; tick();
  endtask

  task automatic test_neq_always();
    cfg_num_stages = 2'd1;
    cfg_write(2'd0, 22'h000000, 22'h00000F, MODE_NEQ, 8'd0, 8'd0);
    cfg_write(2'd1, 22'h000000, 22'h000000, MODE_ALWAYS, 8'd4, 8'd0);
    trig_data = 22'h000010; start = 1'b1; tick();
    tick();
    n_vec++;
    if (current_stage !== 4'd0) begin
      n_err++; $display("FAIL neq_masked_off: cs=%0d expected=0", current_stage);
    end
    trig_data = 22'h000003; tick();
    n_vec++;
    if (current_stage !== 4'd1) begin
      n_err++; $display("FAIL neq_count0_as1: cs=%0d expected=1", current_stage);
    end
    trig_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(4'd1);
      tick();
      n_vec++;
      if (trigger !== (i == 3)) begin
        n_err++; $display("FAIL always_cnt%0d: trig=%b expected=%b", i, trigger, (i == 3));
      end
    end
    start = 1'b0; tick();
  endtask

  task automatic test_four_stages();
    cfg_num_stages = 2'd3;
    for (int s = 0; s < 4; s++) cfg_write(2'(s), '0, '0, MODE_ALWAYS, 8'd1, 8'd0);
    trig_data = '0; start = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(4'd3);
      tick();
      n_vec++;
      if (current_stage !== ((i < 3) ? 4'(i + 1) : 4'd3) || trigger !== (i == 3)) begin
        n_err++; $display("FAIL four_step%0d: cs=%0d trig=%b", i, current_stage, trigger);
      end
    end
    start = 1'b0; tick();
  endtask

  task automatic test_cfg_while_armed();
    cfg_num_stages = 2'd0;
    cfg_write(2'd0, 22'h000005, ALL1, MODE_EQ, 8'd3, 8'd0);
    trig_data = '0; start = 1'b1; tick();
    trig_data = 22'h000005; tick();
    trig_data = '0;
    cfg_write(2'd0, 22'h000005, ALL1, MODE_EQ, 8'd1, 8'd0);
    trig_data = 22'h000005; tick();
    n_vec++;
    if (trigger !== 1'b0) begin
      n_err++; $display("FAIL latched_target: trig=%b expected=0", trigger);
    end
    exp_q.push_back(4'd0); tick();
    n_vec++;
    if (trigger !== 1'b1) begin
      n_err++; $display("FAIL latched_trigger: trig=%b expected=1", trigger);
    end
    start = 1'b0; tick();
  endtask

  task automatic test_timeout();
    cfg_num_stages = 2'd1;
    cfg_write(2'd0, 22'h000001, ALL1, MODE_EQ, 8'd1, 8'd0);
    cfg_write(2'd1, 22'h000002, ALL1, MODE_EQ, 8'd1, 8'd5);
    trig_data = '0; start = 1'b1; tick();
    trig_data = 22'h000001; tick();
    trig_data = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
`ifdef HDLV_TRIG_TIMEOUT_EN
      if (current_stage !== ((i < 4) ? 4'd1 : 4'd0)) begin
`else
      if (current_stage !== 4'd1) begin
`endif
        n_err++; $display("FAIL timeout_cycle%0d: cs=%0d", i, current_stage);
      end
    end
    n_vec++;
    if (stage_reset !== EXP_SR || seq_reset !== EXP_SEQ) begin
      n_err++; $display("FAIL timeout_flags: sr=%b seq=%b expected sr=%b seq=%b",
                        stage_reset, seq_reset, EXP_SR, EXP_SEQ);
    end
    cfg_write(2'd1, 22'h000002, ALL1, MODE_EQ, 8'd1, 8'd3);
    trig_data = 22'h000001; tick();
    n_vec++;
    if (current_stage !== 4'd1) begin
      n_err++; $display("FAIL timeout_reenter_s1: cs=%0d expected=1", current_stage);
    end
    trig_data = '0; tick(); tick();
    trig_data = 22'h000002; exp_q.push_back(4'd1); tick();
    n_vec++;
    if (trigger !== 1'b1 || stage_reset !== EXP_SR || seq_reset !== EXP_SEQ) begin
      n_err++; $display("FAIL timeout_vs_match: trig=%b sr=%b seq=%b expected trig=1 sr=%b seq=%b",
                        trigger, stage_reset, seq_reset, EXP_SR, EXP_SEQ);
    end
    start = 1'b0; tick();
  endtask

  // Sequence all scenarios, then report.
  initial begin
    test_reset();
    test_single_eq();
    test_two_stage_edge();
    test_clk_enable();
    test_start_drop();
    test_neq_always();
    test_four_stages();
    test_cfg_while_armed();
    test_timeout();
    tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_missing_trigger: %0d expected triggers never seen, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
